// File: rtl/etroc2_trig_pkg.sv
// Shared constants and helpers for the column trigger-hit receive path.
// Width encodings, sync word and BCID geometry.
package etroc2_trig_pkg;

  localparam int BCID_W = 12;
  localparam int BCID_MAX_DEF = 3563;

  localparam logic [1:0] TRIG_W1 = 2'd0;
  localparam logic [1:0] TRIG_W2 = 2'd1;
  localparam logic [1:0] TRIG_W4 = 2'd2;
  localparam logic [1:0] TRIG_W8 = 2'd3;

  localparam logic [7:0] SYNC_WORD_DEF = 8'hA5;

  function automatic logic [7:0] width_mask(
    input logic [1:0] sel
  );
    logic [7:0] m;
    m = 8'hFF;
    unique case (sel)
      TRIG_W1: m = 8'h01;
      TRIG_W2: m = 8'h03;
      TRIG_W4: m = 8'h0F;
      TRIG_W8: m = 8'hFF;
    endcase
    return m;
  endfunction

  function automatic logic [3:0] popcount8(
    input logic [7:0] v
  );
    logic [3:0] s;
    s = '0;
    for (int i = 0; i < 8; i++) begin
      s = s + {3'b0, v[i]};
    end
    return s;
  endfunction

endpackage

// File: rtl/trig_hit_merge.sv
// OR-merges the 8 trigger lines down to 1/2/4/8 bits.
// Bits above the selected width are forced to zero.
module trig_hit_merge
  import etroc2_trig_pkg::*;
(
  input  logic [7:0] i_hits,
  input  logic [1:0] i_size,
  output logic [7:0] o_word
);

  always_comb begin
    o_word = '0;
    unique case (i_size)
      TRIG_W1: o_word = {7'b0, |i_hits};
      TRIG_W2: o_word = {6'b0,
                         |i_hits[7:4],
                         |i_hits[3:0]};
      TRIG_W4: o_word = {4'b0,
                         |i_hits[7:6],
                         |i_hits[5:4],
                         |i_hits[3:2],
                         |i_hits[1:0]};
      TRIG_W8: o_word = i_hits;
    endcase
  end

endmodule

// File: rtl/trig_hit_receiver.sv
// Two-stage trigger-hit receiver: merge, orbit sync insertion,
// BCID tagging and per-line saturating hit counters.
module trig_hit_receiver
  import etroc2_trig_pkg::*;
#(
  parameter int         BCID_MAX  = BCID_MAX_DEF,
  parameter int         CNT_W     = 16,
  parameter logic [7:0] SYNC_WORD = SYNC_WORD_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [7:0]        trigHitsIn,
  input  logic [1:0]        trigDataSize,
  input  logic              bcReset,
  input  logic [BCID_W-1:0] bcidOffset,
  input  logic              cntClear,
  input  logic [2:0]        cntSel,
  output logic [7:0]        trigDataOut,
  output logic              syncFlag,
  output logic [BCID_W-1:0] bcidOut,
  output logic [3:0]        hitSum,
  output logic [CNT_W-1:0]  hitCount
);

  logic [BCID_W-1:0] r_bcid;
  logic [BCID_W-1:0] w_bcid_nxt;
  logic [BCID_W-1:0] r_s1_bcid;
  logic [7:0]        r_s1_hits;
  logic [3:0]        r_s1_sum;
  logic [7:0]        r_data;
  logic              r_sync;
  logic [BCID_W-1:0] r_bcid_out;
  logic [3:0]        r_hit_sum;
  logic [CNT_W-1:0]  r_cnt [8];
  logic [CNT_W-1:0]  r_hit_count;
  logic [7:0]        w_merged;
  logic [7:0]        w_sync_word;
  logic              w_s1_sync;

  trig_hit_merge u_merge (
    .i_hits (r_s1_hits),
    .i_size (trigDataSize),
    .o_word (w_merged)
  );

  assign w_sync_word = SYNC_WORD & width_mask(trigDataSize);
  assign w_s1_sync   = (r_s1_bcid == '0);

  // Offsets above BCID_MAX run on to 4095 and wrap naturally.
  always_comb begin
    w_bcid_nxt = r_bcid + 12'd1;
    if (r_bcid == BCID_W'(BCID_MAX)) begin
      w_bcid_nxt = '0;
    end
    if (bcReset) begin
      w_bcid_nxt = bcidOffset;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_bcid <= bcidOffset;
    end else begin
      r_bcid <= w_bcid_nxt;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_s1_hits  <= '0;
      r_s1_bcid  <= '0;
      r_s1_sum   <= '0;
      r_data     <= '0;
      r_sync     <= 1'b0;
      r_bcid_out <= '0;
      r_hit_sum  <= '0;
    end else begin
      r_s1_hits  <= trigHitsIn;
      r_s1_bcid  <= r_bcid;
      r_s1_sum   <= popcount8(trigHitsIn);
      r_data     <= w_s1_sync ? w_sync_word
                              : w_merged;
      r_sync     <= w_s1_sync;
      r_bcid_out <= r_s1_bcid;
      r_hit_sum  <= r_s1_sum;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 8; i++) begin
        r_cnt[i] <= '0;
      end
      r_hit_count <= '0;
    end else begin
      r_hit_count <= r_cnt[cntSel];
      for (int i = 0; i < 8; i++) begin
        if (cntClear) begin
          r_cnt[i] <= '0;
        end else if (r_s1_hits[i] &&
                     (r_cnt[i] != '1)) begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign trigDataOut = r_data;
  assign syncFlag    = r_sync;
  assign bcidOut     = r_bcid_out;
  assign hitSum      = r_hit_sum;
  assign hitCount    = r_hit_count;

endmodule

// File: tb/tb_trig_hit_receiver.sv
// Bench for trig_hit_receiver: directed tables, orbit corners,
// async reset and a random run against a behavioural model.
module tb_trig_hit_receiver;

  localparam int CMAX = 15;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  trigHitsIn = '0;
  logic [1:0]  trigDataSize = '0;
  logic        bcReset = 1'b0;
  logic [11:0] bcidOffset = '0;
  logic        cntClear = 1'b0;
  logic [2:0]  cntSel = '0;
  logic [7:0]  trigDataOut;
  logic        syncFlag;
  logic [11:0] bcidOut;
  logic [3:0]  hitSum;
  logic [3:0]  hitCount;

  int checks = 0;
  int errors = 0;

  trig_hit_receiver #(.CNT_W(4)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .trigHitsIn   (trigHitsIn),
    .trigDataSize (trigDataSize),
    .bcReset      (bcReset),
    .bcidOffset   (bcidOffset),
    .cntClear     (cntClear),
    .cntSel       (cntSel),
    .trigDataOut  (trigDataOut),
    .syncFlag     (syncFlag),
    .bcidOut      (bcidOut),
    .hitSum       (hitSum),
    .hitCount     (hitCount)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  // Model state: orbit counter, last captured BX, hit tallies.
  int         m_bcid;
  int         m_edges;
  logic [7:0] m_h1;
  int         m_b1;
  int         m_cnt [8];
  int         e_data, e_sync, e_bcid, e_sum, e_hc;

  task automatic chk(input string name, input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d",
               name, act, exp);
    end
  endtask

  function automatic int merge_ref(input int hits,
                                   input int sel);
    int w, g, r;
    w = 1 << sel;
    g = 8 / w;
    r = 0;
    for (int k = 0; k < w; k++) begin
      if (((hits >> (k * g)) & ((1 << g) - 1)) != 0)
        r |= (1 << k);
    end
    return r;
  endfunction

  task automatic model_reset();
    m_bcid = int'(bcidOffset);
    m_edges = 0;
    m_h1 = '0;
    m_b1 = 0;
    for (int i = 0; i < 8; i++) m_cnt[i] = 0;
  endtask

  task automatic tick();
    int w;
    @(posedge clk);
    if (!rstn) begin
      model_reset();
    end else begin
      w = 1 << trigDataSize;
      e_sync = (m_b1 == 0) ? 1 : 0;
      e_data = e_sync != 0
             ? (8'hA5 & ((1 << w) - 1))
             : merge_ref(int'(m_h1), int'(trigDataSize));
      e_bcid = m_b1;
      e_sum  = $countones(m_h1);
      e_hc   = m_cnt[cntSel];
      for (int i = 0; i < 8; i++) begin
        if (cntClear) m_cnt[i] = 0;
        else if (m_h1[i] && m_cnt[i] < CMAX) m_cnt[i]++;
      end
      m_h1 = trigHitsIn;
      m_b1 = m_bcid;
      if (bcReset) m_bcid = int'(bcidOffset);
      else if (m_bcid == 3563 || m_bcid == 4095) m_bcid = 0;
      else m_bcid++;
      m_edges++;
    end
    #1;
    if (rstn) begin
      if (m_edges >= 2) begin
        chk("m_data", int'(trigDataOut), e_data);
        chk("m_sync", int'(syncFlag), e_sync);
        chk("m_bcid", int'(bcidOut), e_bcid);
        chk("m_sum", int'(hitSum), e_sum);
      end
      chk("m_hitcount", int'(hitCount), e_hc);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_data"}, int'(trigDataOut), 0);
    chk({tag, "_sync"}, int'(syncFlag), 0);
    chk({tag, "_bcid"}, int'(bcidOut), 0);
    chk({tag, "_sum"}, int'(hitSum), 0);
    chk({tag, "_hc"}, int'(hitCount), 0);
  endtask

  typedef struct {
    logic [1:0] sz;
    logic [7:0] hits;
    logic [7:0] exp;
    int         sum;
  } vec_t;

  vec_t tbl [10];
  int   nsync, seen, prev;
  int   offs [4];

  initial begin
    tbl[0] = '{2'd0, 8'h10, 8'h01, 1};
    tbl[1] = '{2'd1, 8'h10, 8'h02, 1};
    tbl[2] = '{2'd2, 8'h10, 8'h04, 1};
    tbl[3] = '{2'd3, 8'h10, 8'h10, 1};
    tbl[4] = '{2'd0, 8'h81, 8'h01, 2};
    tbl[5] = '{2'd1, 8'hC0, 8'h02, 2};
    tbl[6] = '{2'd2, 8'h0A, 8'h03, 2};
    tbl[7] = '{2'd3, 8'h00, 8'h00, 0};
    tbl[8] = '{2'd1, 8'hF0, 8'h02, 4};
    tbl[9] = '{2'd0, 8'h00, 8'h00, 0};

    // Reset and first-word latency
    bcidOffset = 12'd5;
    trigDataSize = 2'd3;
    #2;
    model_reset();
    chk_zero("rst");
    tick();
    tick();
    chk_zero("rst_hold");
    rstn = 1'b1;
    trigHitsIn = 8'h81;
    tick();
    trigHitsIn = 8'h00;
    tick();
    chk("t1_data", int'(trigDataOut), 8'h81);
    chk("t1_sum", int'(hitSum), 2);
    chk("t1_bcid", int'(bcidOut), 5);

    // Width merge table
    foreach (tbl[i]) begin
      trigDataSize = tbl[i].sz;
      trigHitsIn = tbl[i].hits;
      repeat (3) tick();
      chk("t2_word", int'(trigDataOut), int'(tbl[i].exp));
      chk("t2_sum", int'(hitSum), tbl[i].sum);
    end

    // Orbit wrap and sync insertion
    trigDataSize = 2'd2;
    trigHitsIn = 8'hFF;
    bcidOffset = 12'd3562;
    bcReset = 1'b1;
    tick();
    bcReset = 1'b0;
    for (int i = 0; i < 8 && bcidOut != 12'd3562; i++)
      tick();
    chk("t3_b0", int'(bcidOut), 3562);
    chk("t3_d0", int'(trigDataOut), 8'h0F);
    chk("t3_s0", int'(syncFlag), 0);
    tick();
    chk("t3_b1", int'(bcidOut), 3563);
    chk("t3_d1", int'(trigDataOut), 8'h0F);
    tick();
    chk("t3_b2", int'(bcidOut), 0);
    chk("t3_d2", int'(trigDataOut), 8'h05);
    chk("t3_s2", int'(syncFlag), 1);
    chk("t3_sum2", int'(hitSum), 8);
    tick();
    chk("t3_b3", int'(bcidOut), 1);
    chk("t3_d3", int'(trigDataOut), 8'h0F);
    chk("t3_s3", int'(syncFlag), 0);

    // bcReset on the last BX of the orbit
    bcidOffset = 12'd3560;
    bcReset = 1'b1;
    tick();
    bcReset = 1'b0;
    repeat (3) tick();
    bcidOffset = 12'd100;
    bcReset = 1'b1;
    tick();
    bcReset = 1'b0;
    nsync = 0;
    seen = 0;
    prev = int'(bcidOut);
    for (int i = 0; i < 8; i++) begin
      tick();
      nsync += int'(syncFlag);
      if (prev == 3563 && int'(bcidOut) == 100) seen = 1;
      prev = int'(bcidOut);
    end
    chk("t4_nosync", nsync, 0);
    chk("t4_jump", seen, 1);

    // Counter saturation and clear
    trigHitsIn = 8'h08;
    cntSel = 3'd3;
    cntClear = 1'b1;
    tick();
    cntClear = 1'b0;
    repeat (20) tick();
    chk("t5_sat", int'(hitCount), 15);
    cntClear = 1'b1;
    tick();
    cntClear = 1'b0;
    tick();
    chk("t5_clr", int'(hitCount), 0);
    tick();
    chk("t5_inc", int'(hitCount), 1);
    tick();
    chk("t5_inc2", int'(hitCount), 2);

    // Randomized traffic
    offs[0] = 3561;
    offs[1] = 4093;
    offs[2] = 0;
    offs[3] = 1000;
    for (int n = 0; n < 500; n++) begin
      trigHitsIn = 8'($urandom);
      trigDataSize = 2'($urandom_range(0, 3));
      cntSel = 3'($urandom_range(0, 7));
      bcReset = ($urandom_range(0, 40) == 0);
      bcidOffset = ($urandom_range(0, 1) == 0)
                 ? 12'(offs[$urandom_range(0, 3)])
                 : 12'($urandom_range(0, 4095));
      cntClear = ($urandom_range(0, 80) == 0);
      tick();
    end
    bcReset = 1'b0;
    cntClear = 1'b0;

    // Async reset between edges
    trigHitsIn = 8'hFF;
    trigDataSize = 2'd3;
    repeat (3) tick();
    bcidOffset = 12'd77;
    #3;
    rstn = 1'b0;
    #1;
    chk_zero("t6");
    model_reset();
    tick();
    rstn = 1'b1;
    trigHitsIn = 8'h00;
    tick();
    tick();
    chk("t6_bcid", int'(bcidOut), 77);
    chk("t6_hc", int'(hitCount), 0);
    chk("t6_data", int'(trigDataOut), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/trig_hit_receiver.md
Name: trig_hit_receiver

Overview:
Receive end of the 8-line column trigger-hit bus produced by the per-column adapters. The 16 columns are OR-combined onto those 8 lines.
- Samples the 8 lines once per bunch crossing (one clk = one BX).
- Merges the lines down to the selected trigger-output width and inserts a BCID-aligned sync word once per orbit.
- Keeps per-line saturating hit counters for slow-control readback.
- Sits between the pixel-matrix trigger lines and the trigger serializer.

Parameters:
BCID_MAX, 3563, last BCID value of the orbit; the counter wraps from BCID_MAX to 0.
CNT_W, 16, width of each per-line hit counter.
SYNC_WORD, 8'hA5, pattern sent at BCID 0; masked to the active width.

Ports:
clk  input  1  40 MHz BX clock; all state is on the rising edge.
rstn  input  1  asynchronous active-low reset.
trigHitsIn  input  8  trigger-hit lines from the column adapters; lines 0-3 come from columns with addr[2]=0, lines 4-7 from columns with addr[2]=1.
trigDataSize  input  2  output width select: 0→1 bit, 1→2 bits, 2→4 bits, 3→8 bits.
bcReset  input  1  synchronous BC reset; loads bcidOffset.
bcidOffset  input  12  BCID value loaded on reset and on bcReset.
cntClear  input  1  synchronous clear of all hit counters.
cntSel  input  3  selects the hit counter driven on hitCount.
trigDataOut  output  8  merged trigger word; bits at and above the active width are 0.
syncFlag  output  1  high in the cycle trigDataOut carries the sync word.
bcidOut  output  12  BCID aligned with trigDataOut.
hitSum  output  4  popcount of the 8 lines, aligned with trigDataOut.
hitCount  output  CNT_W  registered value of counter cntSel.

Behaviour:
- Reset (rstn=0, asynchronous): all outputs are 0 and all counters are 0.
  - Stage-1 and stage-2 registers are 0.
  - The bcid register takes bcidOffset as sampled while rstn is low.
  - Output data is invalid until 2 edges after rstn rises.
- Pipeline:
  - Edge N: stage 1 captures trigHitsIn and bcid, and computes hitSum.
  - Edge N+1: stage 2 registers the merged word, syncFlag, bcidOut and hitSum.
  - Latency is exactly 2 cycles from trigHitsIn to trigDataOut. There are no bubbles.
- BCID counter, 12 bit:
  - Increments every cycle and wraps BCID_MAX→0.
  - bcReset=1 at edge N gives bcid=bcidOffset after that edge; it takes priority over increment and wrap.
  - If bcidOffset > BCID_MAX, the counter counts up to 4095, then wraps to 0. No error is flagged.
- Merge, width W = 1/2/4/8:
  - out[k] = OR of trigHitsIn[k*(8/W) +: 8/W] for k < W; out[k] = 0 for k ≥ W.
  - trigDataSize is sampled at stage 2. A change applies to the next registered word and never splits a word.
- Sync:
  - When the stage-1 BCID is 0, stage 2 outputs SYNC_WORD masked to the low W bits, with syncFlag=1.
  - The hits of that BX are discarded from trigDataOut but are still counted and still appear in hitSum.
- Hit counters:
  - Eight CNT_W counters. Counter i increments when stage-1 line i = 1.
  - Each counter saturates at all-ones and holds.
  - cntClear=1 clears all eight; clear wins over a simultaneous increment.
  - hitCount is the registered copy of counter[cntSel], updating 1 cycle after cntSel or the counter changes.
- hitSum: 0..8, unsigned, zero-extended to 4 bits.
- Reset mid-operation: everything returns to the reset state immediately. There is no partial-word output.

Decomposition:
- Shared package `etroc2_trig_pkg`:
  - constants for trigDataSize encodings (TRIG_W1/W2/W4/W8);
  - SYNC_WORD default;
  - BCID_W=12;
  - BCID_MAX default 3563.
- One natural sub-module, `trig_hit_merge`: combinational OR-merge plus width mask. Everything else lives in the top.

Test Plan:
1. Reset and latency:
   - Stimulus: rstn low, then high with bcidOffset=5; trigDataSize=3; trigHitsIn=8'h81 at cycle 0.
   - Response: trigDataOut=8'h81, hitSum=2, bcidOut=5 at cycle 2; all outputs are 0 during reset.
2. Width merge:
   - Stimulus: trigHitsIn=8'h10 with trigDataSize=0/1/2/3.
   - Response: trigDataOut = 8'h01 / 8'h02 / 8'h04 / 8'h10 two cycles later.
3. Orbit wrap and sync:
   - Stimulus: bcidOffset=3562; trigDataSize=2; trigHitsIn=8'hFF constant.
   - Response: bcidOut goes 3562, 3563, 0. At BCID 0, trigDataOut=8'h05 with syncFlag=1; otherwise 8'h0F with syncFlag=0.
4. bcReset wins over wrap:
   - Stimulus: bcReset=1 in the cycle bcid=3563, with bcidOffset=100.
   - Response: next bcid=100 and no sync word is emitted for that orbit.
5. Counter saturation and clear:
   - Stimulus: CNT_W=4; line 3 high for 20 cycles; cntSel=3.
   - Response: hitCount saturates at 15. Asserting cntClear while line 3 is still high gives hitCount=0 next read, then it increments again.
6. Async reset mid-stream:
   - Stimulus: rstn dropped between edges during traffic.
   - Response: all outputs are 0 immediately, before the next edge. Counters are 0 and bcid=bcidOffset.
